// File: rtl/mips_ctrl_fsm.sv
// mips_ctrl_fsm: multi-cycle control sequencer for the 8-bit MIPS datapath.
// Steps each instruction through IF/ID/RR/EX/(MEM)/(RWB), drives the memory
// handshake and datapath strobes, and halts on HALT or on a memory timeout.
module mips_ctrl_fsm #(
    parameter int unsigned MEM_TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] instr_opcode,
    input  logic       mem_ack,
    input  logic       zero_flag,
    output logic [2:0] current_state,
    output logic [3:0] OPCODE,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_sel,
    output logic       ir_load,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       rf_we,
    output logic       halted,
    output logic       mem_err
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned CMP_W = CNT_W + 1;

    localparam logic [3:0] OP_STORE  = 4'd11;
    localparam logic [3:0] OP_BRANCH = 4'd12;
    localparam logic [3:0] OP_LOAD   = 4'd13;
    localparam logic [3:0] OP_HALT   = 4'd15;

    typedef enum logic [2:0] {
        S_IF   = 3'b000,
        S_ID   = 3'b001,
        S_RR   = 3'b010,
        S_EX   = 3'b011,
        S_RWB  = 3'b100,
        S_MEM  = 3'b101,
        S_ILL  = 3'b110,
        S_HALT = 3'b111
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         opcode_q, opcode_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;
    logic               timeout_hit;

    // Count reaches the limit in this cycle if one more unacked cycle is spent
    assign timeout_hit = (CMP_W'(cnt_q) + CMP_W'(1)) >= CMP_W'(MEM_TIMEOUT);

    assign current_state = state_q;
    assign OPCODE        = opcode_q;
    assign mem_err       = err_q;

    // State, latched opcode, timeout count and sticky error registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IF;
            opcode_q <= 4'd0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
        end
    end

    // Next-state and strobe decode; count defaults to zero so any entry clears it
    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        cnt_d    = '0;
        err_d    = err_q;
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        mem_sel  = 1'b0;
        ir_load  = 1'b0;
        pc_inc   = 1'b0;
        pc_load  = 1'b0;
        rf_we    = 1'b0;
        halted   = 1'b0;

        unique case (state_q)
            S_IF: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_load  = 1'b1;
                    pc_inc   = 1'b1;
                    opcode_d = instr_opcode;
                    state_d  = S_ID;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = S_HALT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_ID: state_d = S_RR;
            S_RR: state_d = S_EX;
            S_EX: begin
                pc_load = (opcode_q == OP_BRANCH) && zero_flag;
                case (opcode_q)
                    OP_STORE, OP_LOAD: state_d = S_MEM;
                    OP_BRANCH:         state_d = S_IF;
                    OP_HALT:           state_d = S_HALT;
                    default:           state_d = S_RWB;
                endcase
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_sel = 1'b1;
                mem_we  = (opcode_q == OP_STORE);
                if (mem_ack) begin
                    state_d = (opcode_q == OP_LOAD) ? S_RWB : S_IF;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = S_HALT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RWB: begin
                rf_we   = 1'b1;
                state_d = S_IF;
            end
            S_HALT: halted = 1'b1;
            default: state_d = S_HALT;
        endcase
    end

endmodule

// File: tb/tb_mips_ctrl_fsm.sv
// Testbench for mips_ctrl_fsm: builds the expected per-cycle trace of each
// instruction from the sequencing rules, then replays it against the DUT.
module tb_mips_ctrl_fsm;

    localparam int unsigned TO = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] instr_opcode;
    logic       mem_ack;
    logic       zero_flag;
    logic [2:0] current_state;
    logic [3:0] OPCODE;
    logic       mem_req, mem_we, mem_sel, ir_load, pc_inc, pc_load, rf_we, halted, mem_err;

    mips_ctrl_fsm #(.MEM_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .instr_opcode(instr_opcode), .mem_ack(mem_ack),
        .zero_flag(zero_flag), .current_state(current_state), .OPCODE(OPCODE),
        .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel), .ir_load(ir_load),
        .pc_inc(pc_inc), .pc_load(pc_load), .rf_we(rf_we), .halted(halted),
        .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    // One expected cycle: inputs to drive and outputs to see
    typedef struct {
        logic       ack;
        logic       zf;
        logic [3:0] iop;
        logic [2:0] st;
        logic [8:0] fl;   // {req,sel,we,ir_load,pc_inc,pc_load,rf_we,halted,mem_err}
        logic [3:0] op;
    } step_t;

    step_t q[$];
    logic [3:0] m_op;
    logic       m_err;
    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [2:0] st, input logic [7:0] fl, input logic ack,
                        input logic zf, input logic [3:0] iop);
        step_t s;
        s.ack = ack; s.zf = zf; s.iop = iop; s.st = st;
        s.fl = {fl, m_err}; s.op = m_op;
        q.push_back(s);
    endtask

    task automatic push_halt(input int n);
        for (int i = 0; i < n; i++)
            push(3'd7, 8'b0000_0001, 1'($urandom), 1'($urandom), 4'($urandom));
    endtask

    // Expected trace of one instruction. to_where: 0 none, 1 IF timeout, 2 MEM timeout.
    task automatic gen_instr(input logic [3:0] opc, input int ifw, input int memw,
                             input logic zf_ex, input int to_where, output logic stopped);
        int n;
        logic a;
        stopped = 1'b0;
        n = (to_where == 1) ? TO : ifw + 1;
        for (int i = 0; i < n; i++) begin
            a = (to_where != 1) && (i == n - 1);
            push(3'd0, {1'b1, 1'b0, 1'b0, a, a, 3'b000}, a, 1'($urandom),
                 a ? opc : 4'($urandom));
        end
        if (to_where == 1) begin
            m_err = 1'b1; stopped = 1'b1; push_halt(5); return;
        end
        m_op = opc;
        push(3'd1, 8'h00, 1'b0, 1'($urandom), 4'($urandom));
        push(3'd2, 8'h00, 1'b0, 1'($urandom), 4'($urandom));
        push(3'd3, {5'b0, (opc == 4'd12) && zf_ex, 2'b00}, 1'b0, zf_ex, 4'($urandom));
        if (opc == 4'd11 || opc == 4'd13) begin
            n = (to_where == 2) ? TO : memw + 1;
            for (int i = 0; i < n; i++) begin
                a = (to_where != 2) && (i == n - 1);
                push(3'd5, {1'b1, 1'b1, opc == 4'd11, 5'b0}, a, 1'($urandom), 4'($urandom));
            end
            if (to_where == 2) begin
                m_err = 1'b1; stopped = 1'b1; push_halt(5); return;
            end
            if (opc == 4'd13) push(3'd4, 8'b0000_0010, 1'b0, 1'($urandom), 4'($urandom));
        end else if (opc == 4'd15) begin
            stopped = 1'b1; push_halt(20);
        end else if (opc != 4'd12) begin
            push(3'd4, 8'b0000_0010, 1'b0, 1'($urandom), 4'($urandom));
        end
    endtask

    // Replay up to n queued cycles (all if n < 0); called at posedge+1
    task automatic play(input int n);
        step_t s;
        int k = 0;
        while (q.size() > 0 && (n < 0 || k < n)) begin
            s = q.pop_front();
            mem_ack = s.ack; zero_flag = s.zf; instr_opcode = s.iop;
            @(negedge clk);
            chk("state", 32'(current_state), 32'(s.st));
            chk("strobes", 32'({mem_req, mem_sel, mem_we, ir_load, pc_inc, pc_load,
                                rf_we, halted, mem_err}), 32'(s.fl));
            chk("opcode", 32'(OPCODE), 32'(s.op));
            @(posedge clk); #1;
            k++;
        end
    endtask

    // One-cycle reset with a possibly colliding ack, then check reset state
    task automatic do_reset(input logic ack);
        reset = 1'b1; mem_ack = ack; instr_opcode = 4'($urandom);
        @(posedge clk); #1;
        reset = 1'b0; mem_ack = 1'b0;
        m_op = 4'd0; m_err = 1'b0;
        q.delete();
        #1;
        chk("rst_state", 32'(current_state), 32'd0);
        chk("rst_opcode", 32'(OPCODE), 32'd0);
        chk("rst_err", 32'(mem_err), 32'd0);
        chk("rst_req", 32'({mem_req, mem_sel, rf_we, halted}), 32'b1000);
    endtask

    initial begin
        logic stp;
        reset = 1'b1; mem_ack = 1'b0; zero_flag = 1'b0; instr_opcode = 4'd0;
        m_op = 4'd0; m_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset(1'b0);

        // ALU ops, zero-wait memory
        for (int i = 0; i < 3; i++) gen_instr(4'd2, 0, 0, 1'($urandom), 0, stp);
        play(-1);
        // Load with 3 wait cycles, store, branch taken / not taken
        gen_instr(4'd13, 0, 3, 1'b0, 0, stp);
        gen_instr(4'd11, 1, 0, 1'b1, 0, stp);
        gen_instr(4'd12, 0, 0, 1'b1, 0, stp);
        gen_instr(4'd12, 2, 0, 1'b0, 0, stp);
        // Ack on exactly the last allowed cycle in IF and MEM
        gen_instr(4'd13, TO - 1, TO - 1, 1'b0, 0, stp);
        play(-1);
        // IF timeout, then acks ignored in HALT
        gen_instr(4'd3, 0, 0, 1'b0, 1, stp);
        play(-1);
        do_reset(1'b0);
        // MEM timeout on a store
        gen_instr(4'd11, 0, 0, 1'b0, 2, stp);
        play(-1);
        do_reset(1'b1);
        // HALT opcode holds for 20 cycles
        gen_instr(4'd15, 0, 0, 1'b0, 0, stp);
        play(-1);
        do_reset(1'b0);
        // Reset during MEM with a colliding ack
        gen_instr(4'd13, 0, 2, 1'b0, 0, stp);
        play(5);
        chk("mid_mem", 32'(current_state), 32'd5);
        do_reset(1'b1);
        chk("mid_rfwe", 32'(rf_we), 32'd0);

        // Randomized instruction stream
        for (int i = 0; i < 80; i++) begin
            int tw;
            logic [3:0] opc;
            opc = 4'($urandom);
            tw = ($urandom_range(0, 15) == 0) ? int'($urandom_range(1, 2)) : 0;
            gen_instr(opc, int'($urandom_range(0, TO - 1)), int'($urandom_range(0, TO - 1)),
                      1'($urandom), tw, stp);
            play(-1);
            if (stp) do_reset(1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
